// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector with a LOAD_LAT-deep in-flight load tracker.
// Optional stall counter output is enabled by defining HAZARD_STATS_EN.
module load_use_hazard_unit #(
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned LOAD_LAT     = 1,
   parameter int unsigned HAS_ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic              id_rs_use,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rt_use,
   input  logic              id_memr,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              flush,
   input  logic              mem_wait,
   output logic              stall,
   output logic              id_ex_bubble,
   output logic [2:0]        pending_cnt
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   logic [LOAD_LAT-1:0]             slot_v_q, slot_v_d;
   logic [LOAD_LAT-1:0][REG_AW-1:0] slot_rd_q, slot_rd_d;

   logic rs_live, rt_live;
   logic hit_any, hit, issue;
   logic [2:0] cnt;

   // Register 0 is hard-wired on MIPS, so a zero index can never be a real dependence.
   always_comb begin
      rs_live = id_rs_use & ((HAS_ZERO_REG == 0) || (id_rs != '0));
      rt_live = id_rt_use & ((HAS_ZERO_REG == 0) || (id_rt != '0));
      hit_any = 1'b0;
      for (int unsigned k = 0; k < LOAD_LAT; k++) begin
         if (slot_v_q[k] &&
             ((rs_live && (id_rs == slot_rd_q[k])) ||
              (rt_live && (id_rt == slot_rd_q[k]))))
            hit_any = 1'b1;
      end
      hit   = id_valid & hit_any;
      issue = id_valid & ~hit & ~flush & ~mem_wait;
   end

   always_comb begin
      slot_v_d  = slot_v_q;
      slot_rd_d = slot_rd_q;
      if (!mem_wait) begin
         for (int unsigned k = 1; k < LOAD_LAT; k++) begin
            slot_v_d[k]  = slot_v_q[k-1];
            slot_rd_d[k] = slot_rd_q[k-1];
         end
         slot_v_d[0]  = issue & id_memr;
         slot_rd_d[0] = id_rd;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_v_q  <= '0;
         slot_rd_q <= '0;
      end else begin
         slot_v_q  <= slot_v_d;
         slot_rd_q <= slot_rd_d;
      end
   end

   // mem_wait outranks flush: the flush is re-presented once the freeze lifts.
   always_comb begin
      stall        = 1'b0;
      id_ex_bubble = 1'b0;
      if (!rst) begin
         if (mem_wait) begin
            stall = 1'b1;
         end else if (flush) begin
            id_ex_bubble = 1'b1;
         end else begin
            stall        = hit;
            id_ex_bubble = hit;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int unsigned k = 0; k < LOAD_LAT; k++)
         cnt = cnt + 3'(slot_v_q[k]);
      pending_cnt = rst ? '0 : cnt;
   end

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && !mem_wait && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cycles_q <= '0;
      else     stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboard bench: three DUT configurations (LAT1/zero-reg, LAT2/zero-reg, LAT3/no zero-reg).
module tb_load_use_hazard_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic       rs_use;
      logic [4:0] rt;
      logic       rt_use;
      logic       memr;
      logic [4:0] rd;
      logic       flush;
      logic       mem_wait;
   } in_t;

   typedef struct {
      int          cyc;
      int          dut;
      logic        st;
      logic        bb;
      logic [2:0]  cnt;
      bit          chk_sc;
      logic [31:0] sc;
      string       nm;
   } exp_t;

   in_t        in_s [3];
   logic [2:0] stall_o, bub_o;
   logic [2:0] cnt_o [3];
`ifdef HAZARD_STATS_EN
   logic [31:0] sc_o [3];
`endif

   load_use_hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .HAS_ZERO_REG(1)) u_lat1 (
      .clk(clk), .rst(rst), .id_valid(in_s[0].valid), .id_rs(in_s[0].rs),
      .id_rs_use(in_s[0].rs_use), .id_rt(in_s[0].rt), .id_rt_use(in_s[0].rt_use),
      .id_memr(in_s[0].memr), .id_rd(in_s[0].rd), .flush(in_s[0].flush),
      .mem_wait(in_s[0].mem_wait), .stall(stall_o[0]), .id_ex_bubble(bub_o[0]),
      .pending_cnt(cnt_o[0])
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc_o[0])
`endif
   );

   load_use_hazard_unit #(.REG_AW(5), .LOAD_LAT(2), .HAS_ZERO_REG(1)) u_lat2 (
      .clk(clk), .rst(rst), .id_valid(in_s[1].valid), .id_rs(in_s[1].rs),
      .id_rs_use(in_s[1].rs_use), .id_rt(in_s[1].rt), .id_rt_use(in_s[1].rt_use),
      .id_memr(in_s[1].memr), .id_rd(in_s[1].rd), .flush(in_s[1].flush),
      .mem_wait(in_s[1].mem_wait), .stall(stall_o[1]), .id_ex_bubble(bub_o[1]),
      .pending_cnt(cnt_o[1])
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc_o[1])
`endif
   );

   load_use_hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .HAS_ZERO_REG(0)) u_lat3 (
      .clk(clk), .rst(rst), .id_valid(in_s[2].valid), .id_rs(in_s[2].rs),
      .id_rs_use(in_s[2].rs_use), .id_rt(in_s[2].rt), .id_rt_use(in_s[2].rt_use),
      .id_memr(in_s[2].memr), .id_rd(in_s[2].rd), .flush(in_s[2].flush),
      .mem_wait(in_s[2].mem_wait), .stall(stall_o[2]), .id_ex_bubble(bub_o[2]),
      .pending_cnt(cnt_o[2])
`ifdef HAZARD_STATS_EN
      , .stall_cycles(sc_o[2])
`endif
   );

   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q [$];
   exp_t e;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: retires every expectation tagged with the current cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s stale expectation cyc %0d now %0d", e.nm, e.cyc, cyc);
         end else begin
            if (stall_o[e.dut] !== e.st || bub_o[e.dut] !== e.bb || cnt_o[e.dut] !== e.cnt) begin
               errors++;
               $display("FAIL %s dut%0d stall/bubble/cnt got %b/%b/%0d want %b/%b/%0d",
                        e.nm, e.dut, stall_o[e.dut], bub_o[e.dut], cnt_o[e.dut],
                        e.st, e.bb, e.cnt);
            end
`ifdef HAZARD_STATS_EN
            if (e.chk_sc) begin
               checks++;
               if (sc_o[e.dut] !== e.sc) begin
                  errors++;
                  $display("FAIL %s_stats dut%0d stall_cycles got %0d want %0d",
                           e.nm, e.dut, sc_o[e.dut], e.sc);
               end
            end
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int d, input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic memr,
                      input logic [4:0] rd, input logic fl, input logic mw);
      in_s[d] = '{valid: v, rs: rs, rs_use: rsu, rt: rt, rt_use: rtu, memr: memr,
                  rd: rd, flush: fl, mem_wait: mw};
   endtask

   task automatic idle(input int d);
      in_s[d] = '0;
   endtask

   task automatic ex(input int d, input logic st, input logic bb, input logic [2:0] c,
                     input string nm);
      q.push_back('{cyc: cyc, dut: d, st: st, bb: bb, cnt: c, chk_sc: 1'b0, sc: '0, nm: nm});
   endtask

   task automatic exs(input int d, input logic st, input logic bb, input logic [2:0] c,
                      input logic [31:0] sc, input string nm);
      q.push_back('{cyc: cyc, dut: d, st: st, bb: bb, cnt: c, chk_sc: 1'b1, sc: sc, nm: nm});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) idle(i);
      rst = 1'b1;
      step();
      for (int i = 0; i < 3; i++) exs(i, 0, 0, 0, 0, "reset_state");
      step();
      rst = 1'b0;

      // LOAD_LAT=1: classic single bubble
      step(); drv(0, 1, 2, 1, 0, 0, 1, 8, 0, 0); ex(0, 0, 0, 0, "t1_lw");
      step(); drv(0, 1, 8, 1, 3, 1, 0, 4, 0, 0); ex(0, 1, 1, 1, "t1_dep_stall");
      step();                                   ex(0, 0, 0, 0, "t1_dep_issue");
      step(); idle(0);                          exs(0, 0, 0, 0, 1, "t1_idle");

      // zero register with HAS_ZERO_REG=1
      step(); drv(0, 1, 2, 1, 0, 0, 1, 0, 0, 0); ex(0, 0, 0, 0, "t3a_lw_r0");
      step(); drv(0, 1, 0, 1, 0, 1, 0, 0, 0, 0); ex(0, 0, 0, 1, "t3a_r0_nohit");
      step(); idle(0);                          ex(0, 0, 0, 0, "t3a_drain");

      // LOAD_LAT=3: three stall cycles
      step(); drv(2, 1, 29, 1, 0, 0, 1, 9, 0, 0); ex(2, 0, 0, 0, "t2_lw");
      step(); drv(2, 1, 1, 1, 9, 1, 0, 12, 0, 0); ex(2, 1, 1, 1, "t2_stall1");
      step();                                    ex(2, 1, 1, 1, "t2_stall2");
      step();                                    ex(2, 1, 1, 1, "t2_stall3");
      step();                                    exs(2, 0, 0, 0, 3, "t2_issue");
      step(); idle(2);                           ex(2, 0, 0, 0, "t2_idle");

      // zero register with HAS_ZERO_REG=0 stalls like any register
      step(); drv(2, 1, 4, 1, 0, 0, 1, 0, 0, 0); ex(2, 0, 0, 0, "t3b_lw_r0");
      step(); drv(2, 1, 0, 1, 0, 1, 0, 0, 0, 0); ex(2, 1, 1, 1, "t3b_stall1");
      step();                                   ex(2, 1, 1, 1, "t3b_stall2");
      step();                                   ex(2, 1, 1, 1, "t3b_stall3");
      step();                                   exs(2, 0, 0, 0, 6, "t3b_issue");
      step(); idle(2);                          ex(2, 0, 0, 0, "t3b_idle");

      // LOAD_LAT=2 with mem_wait freezing the slots
      step(); drv(1, 1, 2, 1, 0, 0, 1, 5, 0, 0); ex(1, 0, 0, 0, "t4_lw");
      step(); drv(1, 1, 5, 1, 0, 0, 0, 6, 0, 1); ex(1, 1, 0, 1, "t4_wait1");
      step();                                   ex(1, 1, 0, 1, "t4_wait2");
      step(); drv(1, 1, 5, 1, 0, 0, 0, 6, 0, 0); ex(1, 1, 1, 1, "t4_stall1");
      step();                                   ex(1, 1, 1, 1, "t4_stall2");
      step();                                   exs(1, 0, 0, 0, 2, "t4_issue");
      step(); idle(1);                          ex(1, 0, 0, 0, "t4_idle");

      // flush kills a stalled dependent load; in-flight load drains
      step(); drv(1, 1, 2, 1, 0, 0, 1, 7, 0, 0); ex(1, 0, 0, 0, "t5_lw");
      step(); drv(1, 1, 7, 1, 0, 0, 1, 3, 0, 0); ex(1, 1, 1, 1, "t5_stall");
      step(); drv(1, 1, 7, 1, 0, 0, 1, 3, 1, 0); ex(1, 0, 1, 1, "t5_flush");
      step(); idle(1);                          exs(1, 0, 0, 0, 3, "t5_drained");

      // async reset with two valid slots
      step(); drv(1, 1, 2, 1, 0, 0, 1, 10, 0, 0); ex(1, 0, 0, 0, "t6_lw_a");
      step(); drv(1, 1, 2, 1, 0, 0, 1, 11, 0, 0); ex(1, 0, 0, 1, "t6_lw_b");
      step(); drv(1, 1, 11, 1, 10, 1, 0, 4, 0, 1); ex(1, 1, 0, 2, "t6_two_slots");
      step(); #1 rst = 1'b1;                      exs(1, 0, 0, 0, 0, "t6_rst_mid");
      step(); rst = 1'b0;
      drv(1, 1, 11, 1, 10, 1, 0, 4, 0, 0);       ex(1, 0, 0, 0, "t6_post_rst");
      step(); idle(1);                           exs(1, 0, 0, 0, 0, "t6_idle");

      step();
      step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
